// File: rtl/ntt_stage_sequencer.sv
// Stage/butterfly address sequencer for an in-place DIF NTT.
// Issues read pairs and twiddle addresses and aligns write-back strobes.
module ntt_stage_sequencer #(
    parameter int LOGN        = 8,
    parameter int RD_LAT      = 1,
    parameter int BF_LAT_EVEN = 7,
    parameter int BF_LAT_ODD  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] stage,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr0,
    output logic [LOGN-1:0] rd_addr1,
    output logic [LOGN-2:0] tw_addr,
    output logic            wr_even_en,
    output logic [LOGN-1:0] wr_even_addr,
    output logic            wr_odd_en,
    output logic [LOGN-1:0] wr_odd_addr
);

    localparam int DE = RD_LAT + BF_LAT_EVEN;
    localparam int DO = RD_LAT + BF_LAT_ODD;
    localparam logic [DE-1:0] EV_MASK = {DE{1'b1}} >> 1;
    localparam logic [DO-1:0] OD_MASK = {DO{1'b1}} >> 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [LOGN-1:0] r_stage;
    logic [LOGN-2:0] r_j;

    logic [LOGN-1:0] r_ev_a [DE];
    logic [DE-1:0]   r_ev_v;
    logic [LOGN-1:0] r_od_a [DO];
    logic [DO-1:0]   r_od_v;

    logic            w_rd;
    logic            w_last_j;
    logic            w_last_stage;
    logic            w_drained;
    logic [LOGN-1:0] w_half;
    logic [LOGN-2:0] w_mask;
    logic [LOGN-2:0] w_off;
    logic [LOGN-1:0] w_a0;
    logic [LOGN-1:0] w_a1;

    assign w_rd         = (r_state == S_RUN);
    assign w_last_j     = &r_j;
    assign w_last_stage = (r_stage == LOGN'(LOGN - 1));
    // True in the cycle carrying the final write: nothing behind the outputs
    assign w_drained    = ~|(r_ev_v & EV_MASK) & ~|(r_od_v & OD_MASK);

    // half = N >> (s+1); off = j mod half; group base = (j - off) * 2
    assign w_half = {1'b1, {(LOGN-1){1'b0}}} >> r_stage;
    assign w_mask = w_half[LOGN-2:0] - (LOGN-1)'(1);
    assign w_off  = r_j & w_mask;
    assign w_a0   = {r_j & ~w_mask, 1'b0} | {1'b0, w_off};
    assign w_a1   = w_a0 + w_half;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last_j) w_next = S_DRAIN;
            S_DRAIN: if (w_drained) w_next = w_last_stage ? S_DONE : S_RUN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_j     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start) begin
                    r_stage <= '0;
                    r_j     <= '0;
                end
                S_RUN:   r_j <= r_j + (LOGN-1)'(1);
                S_DRAIN: if (w_drained && !w_last_stage) begin
                    r_stage <= r_stage + LOGN'(1);
                end
                S_DONE:  r_stage <= '0;
                default: r_stage <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ev_v <= '0;
            r_od_v <= '0;
            for (int i = 0; i < DE; i++) r_ev_a[i] <= '0;
            for (int i = 0; i < DO; i++) r_od_a[i] <= '0;
        end else begin
            r_ev_v[0] <= w_rd;
            r_ev_a[0] <= w_a0;
            for (int i = 1; i < DE; i++) begin
                r_ev_v[i] <= r_ev_v[i-1];
                r_ev_a[i] <= r_ev_a[i-1];
            end
            r_od_v[0] <= w_rd;
            r_od_a[0] <= w_a1;
            for (int i = 1; i < DO; i++) begin
                r_od_v[i] <= r_od_v[i-1];
                r_od_a[i] <= r_od_a[i-1];
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign stage        = r_stage;
    assign rd_en        = w_rd;
    assign rd_addr0     = w_rd ? w_a0 : '0;
    assign rd_addr1     = w_rd ? w_a1 : '0;
    assign tw_addr      = w_rd ? (w_off << r_stage) : '0;
    assign wr_even_en   = r_ev_v[DE-1];
    assign wr_even_addr = r_ev_v[DE-1] ? r_ev_a[DE-1] : '0;
    assign wr_odd_en    = r_od_v[DO-1];
    assign wr_odd_addr  = r_od_v[DO-1] ? r_od_a[DO-1] : '0;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Scoreboard bench for ntt_stage_sequencer: LOGN=3 default, LOGN=3
// equal-latency, and LOGN=8 full-run instances.
`timescale 1ns/1ps
module tb_ntt_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, st_a, st_bc;

    logic       a_busy, a_done, a_rd, a_wev, a_wod;
    logic [2:0] a_stage, a_ra0, a_ra1, a_wea, a_woa;
    logic [1:0] a_tw;
    logic       b_busy, b_done, b_rd, b_wev, b_wod;
    logic [2:0] b_stage, b_ra0, b_ra1, b_wea, b_woa;
    logic [1:0] b_tw;
    logic       c_busy, c_done, c_rd, c_wev, c_wod;
    logic [7:0] c_stage, c_ra0, c_ra1, c_wea, c_woa;
    logic [6:0] c_tw;

    ntt_stage_sequencer #(.LOGN(3)) u_a (
        .clk(clk), .reset(rst), .start(st_a), .busy(a_busy), .done(a_done),
        .stage(a_stage), .rd_en(a_rd), .rd_addr0(a_ra0), .rd_addr1(a_ra1),
        .tw_addr(a_tw), .wr_even_en(a_wev), .wr_even_addr(a_wea),
        .wr_odd_en(a_wod), .wr_odd_addr(a_woa));

    ntt_stage_sequencer #(.LOGN(3), .RD_LAT(2), .BF_LAT_EVEN(3), .BF_LAT_ODD(3)) u_b (
        .clk(clk), .reset(rst), .start(st_bc), .busy(b_busy), .done(b_done),
        .stage(b_stage), .rd_en(b_rd), .rd_addr0(b_ra0), .rd_addr1(b_ra1),
        .tw_addr(b_tw), .wr_even_en(b_wev), .wr_even_addr(b_wea),
        .wr_odd_en(b_wod), .wr_odd_addr(b_woa));

    ntt_stage_sequencer #(.LOGN(8)) u_c (
        .clk(clk), .reset(rst), .start(st_bc), .busy(c_busy), .done(c_done),
        .stage(c_stage), .rd_en(c_rd), .rd_addr0(c_ra0), .rd_addr1(c_ra1),
        .tw_addr(c_tw), .wr_even_en(c_wev), .wr_even_addr(c_wea),
        .wr_odd_en(c_wod), .wr_odd_addr(c_woa));

    typedef struct {int c; int a0; int a1; int tw; int s;} rd_t;
    typedef struct {int c; int a;} wr_t;

    rd_t qa_rd[$], qb_rd[$];
    wr_t qa_ev[$], qa_od[$], qb_ev[$], qb_od[$];

    int cyc = 0;
    int n_chk = 0, n_pass = 0;
    int ta0 = -10, exp_done_a = -1, na_done = 0;
    int tb0 = -10, exp_done_b = -1, nb_done = 0;
    int c_first = -1, c_done_c = -1, nc_done = 0, c_nod = 0, c_dup = 0, nc_stage = 0;
    bit c_mark [256];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic void bf(input int logn, input int s, input int j,
                               output int a0, output int a1, output int tw);
        int half;
        half = (1 << logn) >> (s + 1);
        a0 = (j / half) * 2 * half + (j % half);
        a1 = a0 + half;
        tw = (j % half) << s;
    endfunction

    task automatic load_a(input int t0);
        int a0, a1, tw, c;
        for (int s = 0; s < 3; s++)
            for (int j = 0; j < 4; j++) begin
                bf(3, s, j, a0, a1, tw);
                c = t0 + 1 + s * 13 + j;
                qa_rd.push_back('{c, a0, a1, tw, s});
                qa_ev.push_back('{c + 8, a0});
                qa_od.push_back('{c + 9, a1});
            end
        ta0 = t0;
        exp_done_a = t0 + 40;
    endtask

    task automatic load_b(input int t0);
        int a0, a1, tw, c;
        for (int s = 0; s < 3; s++)
            for (int j = 0; j < 4; j++) begin
                bf(3, s, j, a0, a1, tw);
                c = t0 + 1 + s * 9 + j;
                qb_rd.push_back('{c, a0, a1, tw, s});
                qb_ev.push_back('{c + 5, a0});
                qb_od.push_back('{c + 5, a1});
            end
        tb0 = t0;
        exp_done_b = t0 + 28;
    endtask

    always @(negedge clk) begin
        rd_t e;
        wr_t w;
        if (qa_rd.size() > 0 && qa_rd[0].c == cyc) begin
            e = qa_rd.pop_front();
            chk("a_rd_en", a_rd, 1);
            chk("a_rd_addr0", a_ra0, e.a0);
            chk("a_rd_addr1", a_ra1, e.a1);
            chk("a_tw_addr", a_tw, e.tw);
            chk("a_stage", a_stage, e.s);
        end else if (a_rd) chk("a_rd_stray", a_rd, 0);
        if (qa_ev.size() > 0 && qa_ev[0].c == cyc) begin
            w = qa_ev.pop_front();
            chk("a_wr_even_en", a_wev, 1);
            chk("a_wr_even_addr", a_wea, w.a);
        end else if (a_wev) chk("a_wr_even_stray", a_wev, 0);
        if (qa_od.size() > 0 && qa_od[0].c == cyc) begin
            w = qa_od.pop_front();
            chk("a_wr_odd_en", a_wod, 1);
            chk("a_wr_odd_addr", a_woa, w.a);
        end else if (a_wod) chk("a_wr_odd_stray", a_wod, 0);
        chk("a_busy", a_busy, (cyc > ta0 && cyc <= exp_done_a));
        if (a_done) begin
            na_done++;
            chk("a_done_cycle", cyc, exp_done_a);
        end
    end

    always @(negedge clk) begin
        rd_t e;
        wr_t w;
        if (qb_rd.size() > 0 && qb_rd[0].c == cyc) begin
            e = qb_rd.pop_front();
            chk("b_rd_en", b_rd, 1);
            chk("b_rd_addr0", b_ra0, e.a0);
            chk("b_rd_addr1", b_ra1, e.a1);
            chk("b_tw_addr", b_tw, e.tw);
            chk("b_stage", b_stage, e.s);
        end else if (b_rd) chk("b_rd_stray", b_rd, 0);
        if (qb_ev.size() > 0 && qb_ev[0].c == cyc) begin
            w = qb_ev.pop_front();
            chk("b_wr_even_en", b_wev, 1);
            chk("b_wr_even_addr", b_wea, w.a);
        end else if (b_wev) chk("b_wr_even_stray", b_wev, 0);
        if (qb_od.size() > 0 && qb_od[0].c == cyc) begin
            w = qb_od.pop_front();
            chk("b_wr_odd_en", b_wod, 1);
            chk("b_wr_odd_addr", b_woa, w.a);
        end else if (b_wod) chk("b_wr_odd_stray", b_wod, 0);
        chk("b_busy", b_busy, (cyc > tb0 && cyc <= exp_done_b));
        if (b_done) begin
            nb_done++;
            chk("b_done_cycle", cyc, exp_done_b);
        end
    end

    always @(negedge clk) begin
        int cnt;
        if (c_rd && c_first < 0) c_first = cyc;
        if (c_wev) begin
            if (c_mark[c_wea]) c_dup++;
            c_mark[c_wea] = 1'b1;
        end
        if (c_wod) begin
            if (c_mark[c_woa]) c_dup++;
            c_mark[c_woa] = 1'b1;
            c_nod++;
            if (c_nod % 128 == 0) begin
                cnt = 0;
                for (int i = 0; i < 256; i++) cnt += int'(c_mark[i]);
                chk("c_stage_coverage", cnt, 256);
                chk("c_stage_dup_writes", c_dup, 0);
                for (int i = 0; i < 256; i++) c_mark[i] = 1'b0;
                c_dup = 0;
                nc_stage++;
            end
        end
        if (c_done) begin
            nc_done++;
            c_done_c = cyc;
        end
    end

    initial begin
        int t0;
        rst = 1'b1;
        st_a = 1'b0;
        st_bc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {a_busy, a_done, a_stage, a_rd, a_ra0, a_ra1, a_tw,
                            a_wev, a_wea, a_wod, a_woa}, 0);
        rst = 1'b0;

        // clean run on all three instances
        @(posedge clk); #1;
        load_a(cyc);
        load_b(cyc);
        st_a = 1'b1;
        st_bc = 1'b1;
        @(posedge clk); #1;
        st_a = 1'b0;
        st_bc = 1'b0;
        repeat (1110) @(posedge clk);
        #1;
        chk("a_done_count_run1", na_done, 1);
        chk("b_done_count", nb_done, 1);
        chk("c_done_count", nc_done, 1);
        chk("a_queue_left_run1", qa_rd.size() + qa_ev.size() + qa_od.size(), 0);
        chk("b_queue_left", qb_rd.size() + qb_ev.size() + qb_od.size(), 0);
        chk("c_first_rd_to_done", c_done_c - c_first, 1096);
        chk("c_stage_count", nc_stage, 8);

        // start re-pulsed while busy
        t0 = cyc;
        load_a(t0);
        st_a = 1'b1;
        @(posedge clk); #1;
        st_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        st_a = 1'b1;
        @(posedge clk); #1;
        st_a = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        st_a = 1'b1;
        @(posedge clk); #1;
        st_a = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("a_done_count_run2", na_done, 2);
        chk("a_queue_left_run2", qa_rd.size() + qa_ev.size() + qa_od.size(), 0);

        // reset asserted at cycle 11 of a run
        t0 = cyc;
        load_a(t0);
        st_a = 1'b1;
        @(posedge clk); #1;
        st_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        qa_rd.delete();
        qa_ev.delete();
        qa_od.delete();
        ta0 = -10;
        exp_done_a = -1;
        #1;
        chk("mid_reset_outputs", {a_busy, a_done, a_stage, a_rd, a_ra0, a_ra1, a_tw,
                                  a_wev, a_wea, a_wod, a_woa}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("a_done_count_reset", na_done, 2);

        // clean run after reset
        load_a(cyc);
        st_a = 1'b1;
        @(posedge clk); #1;
        st_a = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        chk("a_done_count_run4", na_done, 3);
        chk("a_queue_left_run4", qa_rd.size() + qa_ev.size() + qa_od.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ntt_stage_sequencer.md
Name: ntt_stage_sequencer

Overview:
- Control block directly upstream of the butterfly unit in the in-place NTT datapath.
- Runs all LOGN Gentleman-Sande (DIF) stages over an N=2^LOGN coefficient RAM; the butterfly computes even = a+b and odd = (a-b)*w.
- Per butterfly, issues the read-address pair for NTTin0/NTTin1 and the twiddle ROM address for MULin.
- Delays the same addresses to produce write-back strobes aligned with the butterfly's even and odd outputs, which have different latencies.
- Enforces the inter-stage RAW hazard by draining the pipeline between stages.

Parameters:
- LOGN, 8, log2 of transform size N.
- RD_LAT, 1, cycles from rd_en to coefficient and twiddle data valid at the butterfly inputs.
- BF_LAT_EVEN, 7, butterfly input-to-NTToutEVEN latency.
- BF_LAT_ODD, 8, butterfly input-to-NTToutODD latency; must be >= BF_LAT_EVEN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a full transform; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse when the last write of the last stage has completed.
- stage  out  LOGN bits (sized to hold 0..LOGN-1)  current stage index.
- rd_en  out  1  read strobe to the coefficient RAM and twiddle ROM.
- rd_addr0  out  LOGN  address of butterfly input a.
- rd_addr1  out  LOGN  address of butterfly input b.
- tw_addr  out  LOGN-1  twiddle ROM address.
- wr_even_en  out  1  write strobe for NTToutEVEN.
- wr_even_addr  out  LOGN  write address for NTToutEVEN.
- wr_odd_en  out  1  write strobe for NTToutODD.
- wr_odd_addr  out  LOGN  write address for NTToutODD.

Behaviour:
- Reset, asynchronous: FSM=IDLE; every output 0; all delay-line valid bits cleared, so in-flight writes are discarded. Reset mid-transform behaves identically.
- States and transitions:
  - IDLE: start -> RUN, with stage=0 and j=0.
  - RUN: rd_en=1 every cycle; j counts 0..N/2-1. After j=N/2-1 -> DRAIN.
  - DRAIN: wait until the write pipeline is empty, i.e. the cycle carrying the last wr_odd_en of the stage. Then:
    - if stage<LOGN-1: stage++, j=0, -> RUN;
    - else -> DONE.
  - DONE: done=1 for one cycle, busy=1 -> IDLE.
- Address generation, stage s, index j:
  - half = N>>(s+1); g = j/half; off = j mod half (shift/mask only, no dividers).
  - rd_addr0 = g*2*half + off; rd_addr1 = rd_addr0 + half; tw_addr = off<<s (width LOGN-1, no overflow possible).
- Write alignment:
  - rd_addr0 is delayed RD_LAT+BF_LAT_EVEN cycles to give wr_even_addr/wr_even_en.
  - rd_addr1 is delayed RD_LAT+BF_LAT_ODD cycles to give wr_odd_addr/wr_odd_en.
  - A write strobe is high exactly when the corresponding delayed valid bit is set.
  - The write pipeline is empty when no valid bit is set.
- Overlap: even/odd writes of one butterfly overlap reads of later butterflies in the same stage. Addresses within a stage are disjoint, so this is legal.
- No read of stage s+1 is issued before the last wr_odd_en of stage s. The first rd_en of s+1 falls in the cycle after that write.
- Timing:
  - First rd_en is in the cycle after start is sampled.
  - Cycles per stage = N/2 + RD_LAT + BF_LAT_ODD.
- start while busy: ignored, with no effect on counters.

Test Plan:
- LOGN=3, defaults, start at cycle 0 -> stage 0 reads in cycles 1-4 with pairs (0,4),(1,5),(2,6),(3,7) and tw 0,1,2,3. wr_even_en in cycles 9-12 with addresses 0-3; wr_odd_en in cycles 10-13 with addresses 4-7.
- Same run -> stage 1 reads in cycles 14-17: (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2. Stage 2 reads in cycles 27-30: (0,1),(2,3),(4,5),(6,7), tw 0. Last wr_odd_en at cycle 39, done pulse at cycle 40, then IDLE.
- LOGN=8 full run -> 8 stages of 128+9 cycles each. Every RAM address is written exactly once per stage by even or odd, never both. done occurs 1096 cycles after the first rd_en.
- start re-pulsed at cycles 5 and 20 of a run -> sequence identical to a clean run; no second transform starts.
- reset asserted at cycle 11 of a LOGN=3 run -> all outputs 0 immediately (asynchronous). No write strobe after reset is released. A new start gives a clean stage-0 sequence.
- BF_LAT_EVEN=BF_LAT_ODD=3, RD_LAT=2 -> wr_even and wr_odd of each butterfly are in the same cycle, 5 cycles after its rd_en. Stage period is 4+5 cycles for LOGN=3.
